keccak_state_buffer: RTL and testbench
======================================

Name: keccak_state_buffer

Overview:
- Parametrised, handshaked holder of the Keccak state array A[x][y][z].
- Accepts the state bitstring one lane per beat: overwrite load, or XOR-absorb of the rate portion.
- Streams rate lanes out for squeeze, and accepts a full-state writeback from the round function.
- Sits between the padding/message front end and the permutation core; state_o feeds the round logic directly.

Parameters:
- L, 6, lane-size exponent; W = 2**L bits per lane (1..64); legal L = 0..6.
- RATE_LANES, 17, lanes absorbed/squeezed per block; legal 1..25.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- mode_i  input  2  sampled on start_i: 0 LOAD, 1 ABSORB, 2 SQUEEZE, 3 CLEAR
- start_i  input  1  begin operation (honoured only in IDLE)
- in_valid_i  input  1  input lane valid
- in_ready_o  output  1  input lane accepted when in_valid_i && in_ready_o
- in_lane_i  input  W  lane data; bit k = bitstring[W*(5y+x)+k]
- out_valid_o  output  1  squeeze lane valid
- out_ready_i  input  1  downstream accepts lane
- out_lane_o  output  W  squeeze lane data
- state_we_i  input  1  full-state writeback strobe
- state_i  input  W x 5 x 5  writeback state, indexed [x][y]
- state_o  output  W x 5 x 5  current state, indexed [x][y]
- busy_o  output  1  high in any state other than IDLE
- done_o  output  1  one-cycle pulse on operation completion

Behaviour:
- Reset values: state_o all zero; FSM = IDLE; lane counter = 0; in_ready_o, out_valid_o, busy_o, done_o = 0; out_lane_o = 0.
- Lane order: lane index n = 5y+x, n = 0,1,2,…; counter carries (x,y) incrementally: x wraps 4→0 with y+1. No divider.
- FSM states: IDLE, FILL, DRAIN, CLR.
- IDLE:
  - start_i with mode 0/1 → FILL; mode 2 → DRAIN; mode 3 → CLR.
  - Mode is latched; counter cleared.
- FILL:
  - in_ready_o = 1.
  - Each accepted beat updates A[x][y] at the next edge: LOAD overwrites, ABSORB XORs with in_lane_i. Counter then advances.
  - Last lane is n = 24 for LOAD, n = RATE_LANES-1 for ABSORB. Accepting it → IDLE, with done_o = 1 on the following cycle.
  - No beat → state and counter hold.
- DRAIN:
  - out_valid_o = 1; out_lane_o = A[x][y] of the current counter value (combinational).
  - Value is stable while out_valid_o && !out_ready_i.
  - Advance on handshake; the handshake on lane RATE_LANES-1 → IDLE plus a done_o pulse. State is not modified.
- CLR: zero all lanes in one cycle → IDLE with done_o pulse. Total two cycles start-to-done.
- state_we_i:
  - Honoured only in IDLE with start_i low: state_o <= state_i next edge, done_o pulses.
  - In IDLE, start_i wins over state_we_i (writeback dropped).
  - Ignored outside IDLE.
- start_i while busy: ignored, no queuing.
- done_o is a pulse: at most one cycle high per operation.
- Reset mid-operation: immediate return to reset values; partially filled state discarded.
- Latency: a lane write is visible on state_o one cycle after its handshake.
- in_ready_o and out_valid_o are never high simultaneously.

Optional Feature:
- Macro: KECCAK_LANE_BYTESWAP_EN.
- Defined: in_lane_i is byte-reversed before load/XOR, and out_lane_o is byte-reversed after selection. This gives a big-endian byte interface.
- Macro has no effect when W < 16. state_o and state_i are never swapped.
- Undefined: lanes pass unmodified.

Decomposition:
- Shared package keccak_pkg:
  - mode enum (LOAD/ABSORB/SQUEEZE/CLEAR) and FSM state enum.
  - NUM_LANES = 25 and the lane type parametrised by W.
  - byteswap function.
- One sub-module keccak_lane_cnt: synchronous clear and enable; outputs x, y, n and a last flag given the limit input.

Test Plan:
- LOAD, W=64: lanes n ↦ 64'h0101…01*n for n=0..24 → A[x][y] = that value for 5y+x = n; done_o one cycle after the 25th beat; busy_o low afterwards.
- ABSORB, RATE_LANES=17: preload via LOAD, then absorb all-ones → lanes 0..16 inverted, lanes 17..24 unchanged.
- SQUEEZE with out_ready_i toggling 1,0,0,1…: exactly 17 lanes out in order n=0..16; out_lane_o stable during stalls; state unchanged.
- Reset asserted after 10 LOAD beats → next cycle state all zero, IDLE; the next start_i behaves normally.
- start_i and state_we_i asserted in IDLE together → command starts, writeback dropped. state_we_i during FILL → ignored. start_i during DRAIN → ignored.
- L=3, KECCAK_LANE_BYTESWAP_EN defined vs undefined: 8'hA5 passes unchanged. Then L=4 with the macro: input 16'h1234 stored as 16'h3412 and squeezed back as 16'h1234. CLEAR → zero state in two cycles.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared types for the Keccak state buffer: command/FSM enums,
// lane geometry and the lane byte-reversal helper.
package keccak_pkg;

    localparam int NUM_LANES = 25;
    localparam int MAX_W     = 64;

    typedef enum logic [1:0] {
        MODE_LOAD    = 2'd0,
        MODE_ABSORB  = 2'd1,
        MODE_SQUEEZE = 2'd2,
        MODE_CLEAR   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_CLR   = 2'd3
    } state_e;

    // Widest lane; narrower lanes live in the low bits.
    typedef logic [MAX_W-1:0] lane_t;

    function automatic lane_t byteswap(input lane_t v, input int nbytes);
        lane_t r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (i < nbytes && j == nbytes - 1 - i) begin
                    r[8*i +: 8] = v[8*j +: 8];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/keccak_state_buffer_lane_cnt.sv
// Lane walker: tracks (x,y) and n = 5y+x incrementally, flags the
// lane equal to the supplied limit.
module keccak_lane_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [4:0] limit,
    output logic [2:0] x,
    output logic [2:0] y,
    output logic [4:0] n,
    output logic       last
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            x <= '0;
            y <= '0;
            n <= '0;
        end else if (en) begin
            n <= n + 5'd1;
            if (x == 3'd4) begin
                x <= '0;
                y <= y + 3'd1;
            end else begin
                x <= x + 3'd1;
            end
        end
    end

    assign last = (n == limit);

endmodule

// File: rtl/keccak_state_buffer.sv
// Handshaked Keccak state holder: lane load/absorb, squeeze, clear, writeback.
// Build option: KECCAK_LANE_BYTESWAP_EN gives a big-endian byte lane interface.
module keccak_state_buffer
    import keccak_pkg::*;
#(
    parameter int L          = 6,
    parameter int RATE_LANES = 17,
    localparam int W         = 1 << L
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mode_i,
    input  logic                    start_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [W-1:0]            in_lane_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [W-1:0]            out_lane_o,
    input  logic                    state_we_i,
    input  logic [4:0][4:0][W-1:0]  state_i,
    output logic [4:0][4:0][W-1:0]  state_o,
    output logic                    busy_o,
    output logic                    done_o
);

`ifdef KECCAK_LANE_BYTESWAP_EN
    localparam bit SWAP = (W >= 16);
`else
    localparam bit SWAP = 1'b0;
`endif

    state_e     st;
    mode_e      mode_q;
    logic [2:0] cx;
    logic [2:0] cy;
    logic [4:0] cn;
    logic       last;
    logic [4:0] limit;
    logic       in_hs;
    logic       out_hs;
    logic       start_ok;
    logic [W-1:0] lane_in;
    logic [W-1:0] lane_sel;

    assign in_hs    = in_valid_i && in_ready_o;
    assign out_hs   = out_valid_o && out_ready_i;
    assign start_ok = (st == S_IDLE) && start_i;
    assign limit    = (mode_q == MODE_LOAD) ? 5'd24 : 5'(RATE_LANES - 1);

    keccak_lane_cnt u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ok),
        .en    (in_hs || out_hs),
        .limit (limit),
        .x     (cx),
        .y     (cy),
        .n     (cn),
        .last  (last)
    );

    assign lane_sel = state_o[cx][cy];

    always_comb begin
        lane_in    = in_lane_i;
        out_lane_o = '0;
        if (SWAP) begin
            lane_in = W'(byteswap(lane_t'(in_lane_i), W / 8));
        end
        if (out_valid_o) begin
            out_lane_o = SWAP ? W'(byteswap(lane_t'(lane_sel), W / 8))
                              : lane_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= S_IDLE;
            mode_q      <= MODE_LOAD;
            state_o     <= '0;
            in_ready_o  <= 1'b0;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (st)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q <= mode_e'(mode_i);
                        busy_o <= 1'b1;
                        unique case (mode_e'(mode_i))
                            MODE_LOAD, MODE_ABSORB: begin
                                st         <= S_FILL;
                                in_ready_o <= 1'b1;
                            end
                            MODE_SQUEEZE: begin
                                st          <= S_DRAIN;
                                out_valid_o <= 1'b1;
                            end
                            MODE_CLEAR: st <= S_CLR;
                        endcase
                    end else if (state_we_i) begin
                        state_o <= state_i;
                        done_o  <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (in_hs) begin
                        state_o[cx][cy] <= (mode_q == MODE_LOAD)
                            ? lane_in : (lane_sel ^ lane_in);
                        if (last) begin
                            st         <= S_IDLE;
                            in_ready_o <= 1'b0;
                            busy_o     <= 1'b0;
                            done_o     <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_hs && last) begin
                        st          <= S_IDLE;
                        out_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                    end
                end
                S_CLR: begin
                    state_o <= '0;
                    st      <= S_IDLE;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b1;
                end
            endcase
        end
    end

    logic unused_cn;
    assign unused_cn = ^cn;

endmodule

// File: tb/tb_keccak_state_buffer.sv
// Directed self-checking bench for keccak_state_buffer (W=64 main,
// W=8 and W=16 instances for the byte-lane interface).
module tb_keccak_state_buffer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] ONES01 = 64'h0101010101010101;

    logic [1:0]             mode = '0;
    logic                   start = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [63:0]            in_lane = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [63:0]            out_lane;
    logic                   state_we = 1'b0;
    logic [4:0][4:0][63:0]  st_in = '0;
    logic [4:0][4:0][63:0]  st_out;
    logic                   busy;
    logic                   done;

    logic [1:0]             a_mode = '0;
    logic                   a_start = 1'b0;
    logic                   a_in_valid = 1'b0;
    logic                   a_in_ready;
    logic [7:0]             a_in_lane = '0;
    logic                   a_out_valid;
    logic                   a_out_ready = 1'b0;
    logic [7:0]             a_out_lane;
    logic [4:0][4:0][7:0]   a_st_out;
    logic                   a_busy;
    logic                   a_done;

    logic [1:0]             b_mode = '0;
    logic                   b_start = 1'b0;
    logic                   b_in_valid = 1'b0;
    logic                   b_in_ready;
    logic [15:0]            b_in_lane = '0;
    logic                   b_out_valid;
    logic                   b_out_ready = 1'b0;
    logic [15:0]            b_out_lane;
    logic [4:0][4:0][15:0]  b_st_out;
    logic                   b_busy;
    logic                   b_done;

    logic [63:0] exp_l [25];

    keccak_state_buffer #(.L(6), .RATE_LANES(17)) u_dut (
        .clk(clk), .reset(reset), .mode_i(mode), .start_i(start),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_lane_i(in_lane),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_lane_o(out_lane),
        .state_we_i(state_we), .state_i(st_in), .state_o(st_out),
        .busy_o(busy), .done_o(done)
    );

    keccak_state_buffer #(.L(3), .RATE_LANES(1)) u_d8 (
        .clk(clk), .reset(reset), .mode_i(a_mode), .start_i(a_start),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_lane_i(a_in_lane),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_lane_o(a_out_lane),
        .state_we_i(1'b0), .state_i('0), .state_o(a_st_out),
        .busy_o(a_busy), .done_o(a_done)
    );

    keccak_state_buffer #(.L(4), .RATE_LANES(1)) u_d16 (
        .clk(clk), .reset(reset), .mode_i(b_mode), .start_i(b_start),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_lane_i(b_in_lane),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_lane_o(b_out_lane),
        .state_we_i(1'b0), .state_i('0), .state_o(b_st_out),
        .busy_o(b_busy), .done_o(b_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (st_out !== '0) begin
            errors++; $display("FAIL reset_state got %h want 0", st_out[0][0]);
        end
        checks++;
        if ({busy, done, in_ready, out_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {busy, done, in_ready, out_valid});
        end
        checks++;
        if (out_lane !== 64'h0) begin
            errors++; $display("FAIL reset_out_lane got %h want 0", out_lane);
        end
    endtask

    task automatic test_load;
        mode = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_start got b=%b r=%b v=%b want 1 1 0", busy, in_ready, out_valid);
        end
        for (int n = 0; n < 25; n++) begin
            in_valid = 1'b1;
            in_lane = ONES01 * 64'(n);
            exp_l[n] = ONES01 * 64'(n);
            tick();
            if (n == 1) begin
                checks++;
                if (st_out[1][0] !== ONES01) begin
                    errors++; $display("FAIL load_latency got %h want %h", st_out[1][0], ONES01);
                end
            end
            if (n < 24) begin
                checks++;
                if (done !== 1'b0) begin
                    errors++; $display("FAIL load_early_done lane %0d got %b want 0", n, done);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_done got d=%b b=%b r=%b want 1 0 0", done, busy, in_ready);
        end
        for (int n = 0; n < 25; n++) begin
            checks++;
            if (st_out[n%5][n/5] !== exp_l[n]) begin
                errors++; $display("FAIL load_lane%0d got %h want %h", n, st_out[n%5][n/5], exp_l[n]);
            end
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL load_done_pulse got %b want 0", done);
        end
    endtask

    task automatic test_absorb;
        mode = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 17; n++) begin
            in_valid = 1'b1;
            in_lane = '1;
            exp_l[n] = ~exp_l[n];
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL absorb_done got d=%b b=%b want 1 0", done, busy);
        end
        for (int n = 0; n < 25; n++) begin
            checks++;
            if (st_out[n%5][n/5] !== exp_l[n]) begin
                errors++; $display("FAIL absorb_lane%0d got %h want %h", n, st_out[n%5][n/5], exp_l[n]);
            end
        end
    endtask

    task automatic test_squeeze;
        int got;
        int cyc;
        logic hs;
        got = 0;
        cyc = 0;
        mode = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (got < 17 && cyc < 200) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_lane !== exp_l[got]) begin
                errors++;
                $display("FAIL squeeze_lane%0d got v=%b r=%b %h want 1 0 %h",
                         got, out_valid, in_ready, out_lane, exp_l[got]);
            end
            hs = out_ready;
            tick();
            if (hs) got++;
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (got !== 17) begin
            errors++; $display("FAIL squeeze_count got %0d want 17", got);
        end
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL squeeze_done got d=%b v=%b b=%b want 1 0 0", done, out_valid, busy);
        end
        for (int n = 0; n < 25; n++) begin
            checks++;
            if (st_out[n%5][n/5] !== exp_l[n]) begin
                errors++; $display("FAIL squeeze_keep%0d got %h want %h", n, st_out[n%5][n/5], exp_l[n]);
            end
        end
    endtask

    task automatic test_clear_vs_writeback;
        st_in = {25{64'hAAAA_5555_AAAA_5555}};
        state_we = 1'b1;
        mode = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        state_we = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL clear_busy got b=%b d=%b want 1 0", busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL clear_done got d=%b b=%b want 1 0", done, busy);
        end
        checks++;
        if (st_out !== '0) begin
            errors++; $display("FAIL clear_state got %h want 0", st_out[0][0]);
        end
        for (int n = 0; n < 25; n++) exp_l[n] = '0;
    endtask

    task automatic test_fill_we_and_reset;
        mode = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        st_in = {25{64'h1111_2222_3333_4444}};
        state_we = 1'b1;
        tick();
        state_we = 1'b0;
        checks++;
        if (st_out !== '0) begin
            errors++; $display("FAIL fill_we_ignored got %h want 0", st_out[0][0]);
        end
        for (int n = 0; n < 10; n++) begin
            in_valid = 1'b1;
            in_lane = 64'(n) + 64'd1;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (st_out[4][1] !== 64'd10) begin
            errors++; $display("FAIL partial_fill got %h want a", st_out[4][1]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (st_out !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset got b=%b r=%b lane0=%h want 0 0 0", busy, in_ready, st_out[0][0]);
        end
        mode = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 25; n++) begin
            in_valid = 1'b1;
            in_lane = 64'(n) + 64'h100;
            exp_l[n] = 64'(n) + 64'h100;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || st_out[0][0] !== 64'h100 || st_out[4][4] !== 64'h118) begin
            errors++;
            $display("FAIL reload got d=%b %h %h want 1 100 118", done, st_out[0][0], st_out[4][4]);
        end
    endtask

    task automatic test_writeback;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                st_in[x][y] = 64'hFEED_0000_0000_0000 + 64'(16 * x + y);
        state_we = 1'b1;
        tick();
        state_we = 1'b0;
        checks++;
        if (done !== 1'b1 || st_out !== st_in) begin
            errors++;
            $display("FAIL writeback got d=%b %h want 1 %h", done, st_out[2][3], st_in[2][3]);
        end
        for (int n = 0; n < 25; n++) exp_l[n] = st_in[n%5][n/5];
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL writeback_pulse got %b want 0", done);
        end
    endtask

    task automatic test_start_in_drain;
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        mode = 2'd2;
        start = 1'b1;
        tick();
        mode = 2'd3;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1 || out_lane !== exp_l[0]) begin
            errors++;
            $display("FAIL drain_start_ignored got b=%b v=%b %h want 1 1 %h",
                     busy, out_valid, out_lane, exp_l[0]);
        end
        out_ready = 1'b1;
        while (got < 17 && cyc < 40) begin
            if (out_valid) got++;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (got !== 17 || done !== 1'b1) begin
            errors++; $display("FAIL drain_full got %0d d=%b want 17 1", got, done);
        end
        checks++;
        if (st_out[3][4] !== exp_l[23] || st_out[0][0] !== exp_l[0]) begin
            errors++; $display("FAIL drain_state got %h want %h", st_out[3][4], exp_l[23]);
        end
    endtask

    task automatic test_byteswap;
        logic [15:0] b_exp;
`ifdef KECCAK_LANE_BYTESWAP_EN
        b_exp = 16'h3412;
`else
        b_exp = 16'h1234;
`endif
        a_mode = 2'd1;
        b_mode = 2'd1;
        a_start = 1'b1;
        b_start = 1'b1;
        tick();
        a_start = 1'b0;
        b_start = 1'b0;
        a_in_valid = 1'b1;
        b_in_valid = 1'b1;
        a_in_lane = 8'hA5;
        b_in_lane = 16'h1234;
        tick();
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_st_out[0][0] !== 8'hA5) begin
            errors++; $display("FAIL w8_store got d=%b %h want 1 a5", a_done, a_st_out[0][0]);
        end
        checks++;
        if (b_done !== 1'b1 || b_st_out[0][0] !== b_exp) begin
            errors++; $display("FAIL w16_store got d=%b %h want 1 %h", b_done, b_st_out[0][0], b_exp);
        end
        a_mode = 2'd2;
        b_mode = 2'd2;
        a_start = 1'b1;
        b_start = 1'b1;
        tick();
        a_start = 1'b0;
        b_start = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_lane !== 8'hA5) begin
            errors++; $display("FAIL w8_squeeze got v=%b %h want 1 a5", a_out_valid, a_out_lane);
        end
        checks++;
        if (b_out_valid !== 1'b1 || b_out_lane !== 16'h1234) begin
            errors++; $display("FAIL w16_squeeze got v=%b %h want 1 1234", b_out_valid, b_out_lane);
        end
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        checks++;
        if (a_done !== 1'b1 || b_done !== 1'b1 || a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL small_squeeze_done got %b%b%b%b want 1100",
                     a_done, b_done, a_out_valid, b_out_valid);
        end
        b_mode = 2'd3;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        checks++;
        if (b_busy !== 1'b1 || b_done !== 1'b0) begin
            errors++; $display("FAIL w16_clear_busy got b=%b d=%b want 1 0", b_busy, b_done);
        end
        tick();
        checks++;
        if (b_done !== 1'b1 || b_st_out !== '0) begin
            errors++; $display("FAIL w16_clear got d=%b %h want 1 0", b_done, b_st_out[0][0]);
        end
        checks++;
        if (a_busy !== 1'b0 || a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
            errors++; $display("FAIL small_idle got %b%b%b want 000", a_busy, a_in_ready, b_in_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_absorb();
        test_squeeze();
        test_clear_vs_writeback();
        test_fill_we_and_reset();
        test_writeback();
        test_start_in_drain();
        test_byteswap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
